// File: rtl/csr_req_sequencer_if.sv
// CSR request types plus the writeback/CSR-file bundle of csr_req_sequencer.
// slave: the sequencer; master: the writeback stage and CSR file around it.
package drac_pkg;
    typedef enum logic [2:0] {
        CSR_CMD_NOPE  = 3'd0,
        CSR_CMD_WRITE = 3'd1,
        CSR_CMD_SET   = 3'd2,
        CSR_CMD_CLEAR = 3'd3,
        CSR_CMD_READ  = 3'd5
    } csr_cmd_t;

    typedef struct packed {
        logic [11:0] csr_rw_addr;
        csr_cmd_t    csr_rw_cmd;
        logic [63:0] csr_rw_data;
        logic        csr_exception;
        logic        csr_retire;
    } req_cpu_csr_t;
endpackage

interface csr_req_sequencer_if;
    import drac_pkg::*;

    req_cpu_csr_t req_cpu_csr_i;
    logic         wb_csr_ena_i;
    logic         kill_i;
    logic         csr_ready_i;
    logic         csr_resp_valid_i;
    logic         csr_replay_i;
    logic [63:0]  csr_rdata_i;
    req_cpu_csr_t req_cpu_csr_o;
    logic         csr_req_valid_o;
    logic         stall_wb_o;
    logic [63:0]  csr_rdata_o;
    logic         csr_rdata_valid_o;
    logic         csr_error_o;

    modport slave (
        input  req_cpu_csr_i, wb_csr_ena_i, kill_i, csr_ready_i,
        input  csr_resp_valid_i, csr_replay_i, csr_rdata_i,
        output req_cpu_csr_o, csr_req_valid_o, stall_wb_o,
        output csr_rdata_o, csr_rdata_valid_o, csr_error_o
    );

    modport master (
        output req_cpu_csr_i, wb_csr_ena_i, kill_i, csr_ready_i,
        output csr_resp_valid_i, csr_replay_i, csr_rdata_i,
        input  req_cpu_csr_o, csr_req_valid_o, stall_wb_o,
        input  csr_rdata_o, csr_rdata_valid_o, csr_error_o
    );
endinterface

// File: rtl/csr_req_sequencer.sv
// Holds a writeback CSR command until the CSR file takes it, handles replay
// and timeout, stalls writeback meanwhile. Ports: clk_i, rstn_i, bus (slave).
module csr_req_sequencer
    import drac_pkg::*;
#(
    parameter int MAX_REPLAY     = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    csr_req_sequencer_if.slave   bus
);
    localparam int RW = $clog2(MAX_REPLAY + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t       state;
    req_cpu_csr_t req_q;
    logic [63:0]  rdata_q;
    logic [RW-1:0] replay_cnt;
    logic [TW-1:0] tmo_cnt;
    logic         killed;
    logic         err;

    // A response is taken in WAIT, or in the ISSUE cycle that is accepted.
    logic take_resp;
    logic can_replay;

    assign take_resp = bus.csr_resp_valid_i &&
        ((state == WAIT) ||
         (state == ISSUE && bus.csr_ready_i && !bus.kill_i));
    assign can_replay = replay_cnt < RW'(MAX_REPLAY);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            req_q      <= '0;
            rdata_q    <= '0;
            replay_cnt <= '0;
            tmo_cnt    <= '0;
            killed     <= 1'b0;
            err        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.wb_csr_ena_i && !bus.kill_i) begin
                        req_q      <= bus.req_cpu_csr_i;
                        replay_cnt <= '0;
                        rdata_q    <= '0;
                        killed     <= 1'b0;
                        err        <= 1'b0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.kill_i) begin
                        killed <= 1'b0;
                        err    <= 1'b0;
                        state  <= IDLE;
                    end else if (bus.csr_ready_i) begin
                        tmo_cnt <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    // The command already sits in the CSR file: remember
                    // the flush but still consume its response.
                    if (bus.kill_i) killed <= 1'b1;
                    if (!bus.csr_resp_valid_i) begin
                        if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                            err     <= 1'b1;
                            rdata_q <= '0;
                            state   <= DONE;
                        end else begin
                            tmo_cnt <= tmo_cnt + TW'(1);
                        end
                    end
                end
                DONE: begin
                    killed <= 1'b0;
                    err    <= 1'b0;
                    state  <= IDLE;
                end
            endcase

            if (take_resp) begin
                if (!bus.csr_replay_i) begin
                    rdata_q <= bus.csr_rdata_i;
                    state   <= DONE;
                end else if (can_replay) begin
                    replay_cnt <= replay_cnt + RW'(1);
                    state      <= ISSUE;
                end else begin
                    err     <= 1'b1;
                    rdata_q <= '0;
                    state   <= DONE;
                end
            end
        end
    end

    always_comb begin
        bus.req_cpu_csr_o     = '0;
        bus.csr_req_valid_o   = 1'b0;
        bus.stall_wb_o        = 1'b0;
        bus.csr_rdata_o       = '0;
        bus.csr_rdata_valid_o = 1'b0;
        bus.csr_error_o       = 1'b0;
        if (rstn_i) begin
            unique case (state)
                IDLE: begin
                    bus.req_cpu_csr_o = bus.req_cpu_csr_i;
                    if (bus.wb_csr_ena_i)
                        bus.req_cpu_csr_o.csr_rw_cmd = CSR_CMD_NOPE;
                    bus.stall_wb_o = bus.wb_csr_ena_i && !bus.kill_i;
                end
                ISSUE: begin
                    bus.req_cpu_csr_o               = req_q;
                    bus.req_cpu_csr_o.csr_retire    = 1'b0;
                    bus.req_cpu_csr_o.csr_exception = 1'b0;
                    // A flushed command is never offered to the CSR file.
                    if (bus.kill_i)
                        bus.req_cpu_csr_o.csr_rw_cmd = CSR_CMD_NOPE;
                    bus.csr_req_valid_o = !bus.kill_i;
                    bus.stall_wb_o      = 1'b1;
                end
                WAIT: begin
                    bus.req_cpu_csr_o               = req_q;
                    bus.req_cpu_csr_o.csr_rw_cmd    = CSR_CMD_NOPE;
                    bus.req_cpu_csr_o.csr_retire    = 1'b0;
                    bus.req_cpu_csr_o.csr_exception = 1'b0;
                    bus.stall_wb_o                  = 1'b1;
                end
                DONE: begin
                    bus.req_cpu_csr_o            = req_q;
                    bus.req_cpu_csr_o.csr_rw_cmd = CSR_CMD_NOPE;
                    bus.req_cpu_csr_o.csr_retire =
                        req_q.csr_retire && !killed && !err;
                    bus.req_cpu_csr_o.csr_exception =
                        req_q.csr_exception && !killed;
                    bus.csr_rdata_o       = rdata_q;
                    bus.csr_rdata_valid_o = !killed && !err;
                    bus.csr_error_o       = err && !killed;
                end
            endcase
        end
    end

    // The CSR file must only answer a command it has been given.
    a_resp_in_txn: assert property (@(posedge clk_i) disable iff (!rstn_i)
        bus.csr_resp_valid_i |-> (state == ISSUE || state == WAIT));

endmodule

// File: tb/tb_csr_req_sequencer.sv
// Randomized bench for csr_req_sequencer: a per-cycle plan of stimulus and
// expected outputs is built from transaction-level rules, then replayed.
module tb_csr_req_sequencer;
    import drac_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    csr_req_sequencer_if bus();

    csr_req_sequencer #(
        .MAX_REPLAY(3),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_i(clk),
        .rstn_i(rstn),
        .bus(bus)
    );

    typedef struct {
        bit ena, kill, ready, resp, replay;
        logic [63:0] rdata;
        bit idle, issue, done;
        bit stall, valid;
        bit rvalid, xerr, retire, chk_rdata;
        logic [63:0] exp_rdata;
    } step_t;

    step_t        plan[$];
    req_cpu_csr_t cap;
    int           exp_issues;
    int           n_issue;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic req_cpu_csr_t rand_req();
        req_cpu_csr_t r;
        csr_cmd_t cmds[4] = '{CSR_CMD_WRITE, CSR_CMD_SET,
                              CSR_CMD_CLEAR, CSR_CMD_READ};
        r.csr_rw_addr   = 12'($urandom);
        r.csr_rw_cmd    = cmds[$urandom_range(0, 3)];
        r.csr_rw_data   = {$urandom, $urandom};
        r.csr_exception = 1'($urandom);
        r.csr_retire    = 1'($urandom);
        return r;
    endfunction

    task automatic push_idle();
        step_t s = '{default: 0};
        s.idle = 1;
        plan.push_back(s);
    endtask

    // Build the cycle plan for one transaction. nrep = replay responses
    // before the final one (4 means the limit is exceeded); rdy/wt/fw
    // negative pick random delays; kmode 0 none, 1 kill in first ISSUE,
    // 2 kill in final WAIT, 3 kill at capture.
    task automatic txn(input int nrep, input int rdy, input int wt,
                       input bit tmo, input int fw, input int kmode,
                       input int kat, input logic [63:0] fd);
        step_t s;
        int att, d, w, kl;
        bit lastp, rep, tmo_e, noresp, killed, err;
        plan.delete();
        exp_issues = 0;
        killed = 0;
        tmo_e = tmo && nrep < 4;
        s = '{default: 0};
        s.ena = 1;
        s.idle = 1;
        if (kmode == 3) begin
            s.kill = 1;
            plan.push_back(s);
            push_idle();
            return;
        end
        s.stall = 1;
        plan.push_back(s);
        att = (nrep >= 4) ? 4 : nrep + 1;
        for (int a = 0; a < att; a++) begin
            lastp = (a == att - 1);
            rep = !lastp || nrep >= 4;
            d = (rdy < 0) ? $urandom_range(0, 3) : rdy;
            if (kmode == 1 && d < kat) d = kat;
            if (lastp && !rep) w = (fw < 0) ? $urandom_range(0, 3) : fw;
            else w = (wt < 0) ? $urandom_range(0, 3) : wt;
            noresp = tmo_e && lastp;
            if (noresp) w = 64;
            if (kmode == 2 && lastp && w < 1) w = 1;
            kl = (kat < 1) ? 1 : ((kat > w) ? w : kat);
            for (int j = 0; j <= d; j++) begin
                s = '{default: 0};
                s.ena = 1;
                s.stall = 1;
                s.issue = 1;
                s.rdata = {$urandom, $urandom};
                if (kmode == 1 && a == 0 && j == kat) begin
                    s.kill = 1;
                    s.ready = 1;
                    plan.push_back(s);
                    push_idle();
                    return;
                end
                s.valid = 1;
                s.ready = (j == d);
                if (j == d && w == 0 && !noresp) begin
                    s.resp = 1;
                    s.replay = rep;
                    if (!rep) s.rdata = fd;
                end
                plan.push_back(s);
            end
            exp_issues++;
            for (int k = 1; k <= w; k++) begin
                s = '{default: 0};
                s.ena = 1;
                s.stall = 1;
                s.rdata = {$urandom, $urandom};
                if (k == w && !noresp) begin
                    s.resp = 1;
                    s.replay = rep;
                    if (!rep) s.rdata = fd;
                end
                if (kmode == 2 && lastp && k == kl) begin
                    s.kill = 1;
                    killed = 1;
                end
                plan.push_back(s);
            end
        end
        err = (nrep >= 4) || tmo_e;
        s = '{default: 0};
        s.ena = 1;
        s.done = 1;
        s.rvalid = !killed && !err;
        s.xerr = err && !killed;
        s.retire = cap.csr_retire && !killed && !err;
        s.chk_rdata = !killed && (!err || tmo_e);
        s.exp_rdata = err ? 64'h0 : fd;
        plan.push_back(s);
        push_idle();
    endtask

    task automatic run_plan(input int upto);
        req_cpu_csr_t rin, exp;
        step_t s;
        n_issue = 0;
        for (int i = 0; i < plan.size() && i < upto; i++) begin
            s = plan[i];
            rin = (i == 0) ? cap : rand_req();
            #1;
            bus.req_cpu_csr_i    = rin;
            bus.wb_csr_ena_i     = s.ena;
            bus.kill_i           = s.kill;
            bus.csr_ready_i      = s.ready;
            bus.csr_resp_valid_i = s.resp;
            bus.csr_replay_i     = s.replay;
            bus.csr_rdata_i      = s.rdata;
            @(negedge clk);
            if (bus.csr_req_valid_o && bus.csr_ready_i) n_issue++;
            check("stall", 128'(bus.stall_wb_o), 128'(s.stall));
            check("req_valid", 128'(bus.csr_req_valid_o), 128'(s.valid));
            if (s.idle) begin
                exp = rin;
                if (s.ena) exp.csr_rw_cmd = CSR_CMD_NOPE;
                check("passthru", 128'(bus.req_cpu_csr_o), 128'(exp));
            end
            if (s.issue && s.valid) begin
                exp = cap;
                exp.csr_retire = 1'b0;
                exp.csr_exception = 1'b0;
                check("req_hold", 128'(bus.req_cpu_csr_o), 128'(exp));
            end
            if (s.done) begin
                check("rdata_valid", 128'(bus.csr_rdata_valid_o), 128'(s.rvalid));
                check("error", 128'(bus.csr_error_o), 128'(s.xerr));
                check("retire", 128'(bus.req_cpu_csr_o.csr_retire), 128'(s.retire));
                if (s.chk_rdata)
                    check("rdata", 128'(bus.csr_rdata_o), 128'(s.exp_rdata));
            end else begin
                check("no_rvalid", 128'(bus.csr_rdata_valid_o), 128'(0));
                check("no_error", 128'(bus.csr_error_o), 128'(0));
            end
            @(posedge clk);
        end
    endtask

    task automatic check_zero(string tag);
        check({tag, "_stall"}, 128'(bus.stall_wb_o), 128'(0));
        check({tag, "_valid"}, 128'(bus.csr_req_valid_o), 128'(0));
        check({tag, "_rvalid"}, 128'(bus.csr_rdata_valid_o), 128'(0));
        check({tag, "_err"}, 128'(bus.csr_error_o), 128'(0));
        check({tag, "_rdata"}, 128'(bus.csr_rdata_o), 128'(0));
        check({tag, "_req"}, 128'(bus.req_cpu_csr_o), 128'(0));
    endtask

    task automatic full(input int nrep, input int rdy, input int wt,
                        input bit tmo, input int fw, input int kmode,
                        input int kat, input logic [63:0] fd);
        txn(nrep, rdy, wt, tmo, fw, kmode, kat, fd);
        run_plan(1000);
        check("issues", 128'(n_issue), 128'(exp_issues));
    endtask

    initial begin
        bus.req_cpu_csr_i    = rand_req();
        bus.wb_csr_ena_i     = 1'b1;
        bus.kill_i           = 1'b0;
        bus.csr_ready_i      = 1'b0;
        bus.csr_resp_valid_i = 1'b0;
        bus.csr_replay_i     = 1'b0;
        bus.csr_rdata_i      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;
        bus.wb_csr_ena_i = 1'b0;
        @(posedge clk);

        // CSRRS mcycle, minimum latency
        cap = rand_req();
        cap.csr_rw_cmd = CSR_CMD_SET;
        cap.csr_rw_addr = 12'hB00;
        cap.csr_retire = 1'b1;
        full(0, 0, 0, 0, 0, 0, 0, 64'h1234);
        // CSR file busy for 5 cycles
        cap = rand_req();
        full(0, 5, 0, 0, 2, 0, 0, {$urandom, $urandom});
        // 3 replays then 0xAB; then limit exceeded
        cap = rand_req();
        cap.csr_retire = 1'b1;
        full(3, -1, -1, 0, 1, 0, 0, 64'hAB);
        cap = rand_req();
        cap.csr_retire = 1'b1;
        full(4, -1, -1, 0, 1, 0, 0, 64'hAB);
        // timeout, then a response in the last WAIT cycle
        cap = rand_req();
        full(0, 1, 0, 1, 0, 0, 0, 64'h55);
        cap = rand_req();
        cap.csr_retire = 1'b1;
        full(0, 0, 0, 0, 64, 0, 0, 64'hCAFE);
        // kill in ISSUE with ready high; kill in WAIT
        cap = rand_req();
        full(0, 3, 0, 0, 0, 1, 2, 64'h1);
        cap = rand_req();
        cap.csr_retire = 1'b1;
        full(0, 0, 0, 0, 3, 2, 1, 64'h2);
        // kill at capture
        cap = rand_req();
        full(0, 0, 0, 0, 0, 3, 0, 64'h3);
        // non-CSR retire passes through
        cap = rand_req();
        cap.csr_retire = 1'b1;
        plan.delete();
        push_idle();
        run_plan(1);

        for (int t = 0; t < 60; t++) begin
            int k;
            k = $urandom_range(0, 8);
            cap = rand_req();
            full($urandom_range(0, 4), -1, -1, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 5), (k < 6) ? 0 : k - 5,
                 $urandom_range(0, 3), {$urandom, $urandom});
        end

        // reset while waiting for a response
        cap = rand_req();
        txn(0, 0, 0, 0, 20, 0, 0, 64'h77);
        run_plan(5);
        #1;
        bus.wb_csr_ena_i = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        check_zero("rst_wait");
        @(negedge clk);
        bus.wb_csr_ena_i = 1'b0;
        rstn = 1'b1;
        @(posedge clk);
        cap = rand_req();
        plan.delete();
        push_idle();
        push_idle();
        run_plan(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
